// File: rtl/sprite_blit_if.sv
// rtl/sprite_blit_if.sv - command, program-memory and display-port bundle of the sprite blitter
//
// master modport: the blitter (drives status, program-memory read and display write port)
// slave modport : the surroundings (command source, program memory, display memory)
//   start/x/y/n/i/plane : draw command, sampled by the blitter on an accepted start
//   busy/done/collision : draw status
//   mem_addr/mem_rd     : sprite byte read request; mem_data returns one cycle later
//   hpos/vpos/we/pixeli : display pixel address, write enable and write data
//   pixelo              : display pixel read data, one cycle after hpos/vpos
interface sprite_blit_if;
  logic        start;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [3:0]  n;
  logic [11:0] i;
  logic [1:0]  plane;
  logic        busy;
  logic        done;
  logic        collision;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [6:0]  hpos;
  logic [5:0]  vpos;
  logic [1:0]  pixelo;
  logic [1:0]  pixeli;
  logic        we;

  modport master (
    input  start, x, y, n, i, plane, mem_data, pixelo,
    output busy, done, collision, mem_addr, mem_rd, hpos, vpos, pixeli, we
  );

  modport slave (
    output start, x, y, n, i, plane, mem_data, pixelo,
    input  busy, done, collision, mem_addr, mem_rd, hpos, vpos, pixeli, we
  );
endinterface

// File: rtl/sprite_blit.sv
// rtl/sprite_blit.sv - sprite draw engine for the 128x64 2-bpp display memory
//
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   bus   : sprite_blit_if.master (command, status, program-memory and display port)
// Optional feature: BLIT_CLIP_EN - when defined, pixels past column 127 or row 63 are
// skipped (no write, no collision); otherwise hpos/vpos wrap modulo 128/64.
module sprite_blit (
  input  logic          clk,
  input  logic          reset,
  sprite_blit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_READ,
    S_MODIFY,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [6:0]  r_x;
  logic [5:0]  r_y;
  logic [3:0]  r_n;
  logic [11:0] r_i;
  logic [1:0]  r_plane;
  logic [3:0]  r_row;
  logic [2:0]  r_col;
  logic [7:0]  r_shift;
  logic        r_busy;
  logic        r_done;
  logic        r_collision;
  logic        r_mem_rd;
  logic        r_we;
  logic [11:0] r_mem_addr;
  logic [6:0]  r_hpos;
  logic [5:0]  r_vpos;

  logic [3:0]  w_row_nx;
  logic        w_last_row;
  logic [11:0] w_next_addr;
  logic [6:0]  w_hpos_nx;
  logic [5:0]  w_vpos;
  logic        w_visible;
  logic        w_write;
  logic        w_hit;

  assign w_row_nx    = r_row + 4'd1;
  // 5-bit compare so row+1 can never wrap before it is compared against n
  assign w_last_row  = ({1'b0, r_row} + 5'd1) >= {1'b0, r_n};
  assign w_next_addr = r_i + {8'd0, w_row_nx};
  assign w_hpos_nx   = r_x + {4'd0, r_col} + 7'd1;
  assign w_vpos      = r_y + {2'd0, r_row};

`ifdef BLIT_CLIP_EN
  // widened sums: a carry into bit 7 / bit 6 means the pixel is off-screen
  assign w_visible = (({1'b0, r_x} + {5'd0, r_col}) <= 8'd127) &&
                     (({1'b0, r_y} + {3'd0, r_row}) <= 7'd63);
`else
  assign w_visible = 1'b1;
`endif

  // the shift register is pre-aligned so bit 7 is always the current column's sprite bit;
  // a zero plane mask would rewrite the same value, so it is treated as "no write"
  assign w_write = r_shift[7] & w_visible & (|r_plane);
  assign w_hit   = |(bus.pixelo & r_plane);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_n         <= '0;
      r_i         <= '0;
      r_plane     <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_shift     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_collision <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_hpos      <= '0;
      r_vpos      <= '0;
    end else begin
      r_done   <= 1'b0;
      r_mem_rd <= 1'b0;
      r_we     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_x         <= bus.x;
            r_y         <= bus.y;
            r_n         <= bus.n;
            r_i         <= bus.i;
            r_plane     <= bus.plane;
            r_row       <= '0;
            r_col       <= '0;
            r_collision <= 1'b0;
            r_busy      <= 1'b1;
            if (bus.n == 4'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_FETCH;
              r_mem_addr <= bus.i;
              r_mem_rd   <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_shift <= bus.mem_data;
          r_hpos  <= r_x;
          r_vpos  <= w_vpos;
          r_state <= S_READ;
        end
        S_READ: begin
          r_we    <= w_write;
          r_state <= S_MODIFY;
        end
        S_MODIFY: begin
          // r_we being high here means this pixel is the one being written
          if (r_we && w_hit) begin
            r_collision <= 1'b1;
          end
          r_shift <= {r_shift[6:0], 1'b0};
          if (r_col != 3'd7) begin
            r_col   <= r_col + 3'd1;
            r_hpos  <= w_hpos_nx;
            r_state <= S_READ;
          end else if (!w_last_row) begin
            r_row      <= w_row_nx;
            r_col      <= '0;
            r_mem_addr <= w_next_addr;
            r_mem_rd   <= 1'b1;
            r_state    <= S_FETCH;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.collision = r_collision;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.hpos      = r_hpos;
  assign bus.vpos      = r_vpos;
  assign bus.we        = r_we;
  assign bus.pixeli    = bus.pixelo ^ r_plane;

endmodule

// File: tb/tb_sprite_blit.sv
// tb/tb_sprite_blit.sv - self-checking bench for sprite_blit against a pixel-level draw model
module tb_sprite_blit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sprite_blit_if bif();
  sprite_blit u_dut (.clk(clk), .reset(reset), .bus(bif));

  logic [1:0]  disp  [0:63][0:127];
  logic [1:0]  mdisp [0:63][0:127];
  logic [7:0]  prog  [0:4095];
  logic        tb_clr = 1'b0;
  logic [1:0]  cur_plane = 2'b00;
  int          mon_we = 0;
  int          mon_rd = 0;
  int          mon_pix = 0;
  logic [11:0] mon_rd_last = 12'd0;
  logic [11:0] mon_rd_prev = 12'd0;
  int          total = 0;
  int          bad = 0;

  // display memory (registered read, write on we) and program memory
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int v = 0; v < 64; v++)
        for (int h = 0; h < 128; h++)
          disp[v][h] <= 2'b00;
    end else if (bif.we === 1'b1) begin
      disp[bif.vpos][bif.hpos] <= bif.pixeli;
    end
    bif.pixelo <= disp[bif.vpos][bif.hpos];
    if (bif.mem_rd === 1'b1) bif.mem_data <= prog[bif.mem_addr];
  end

  always @(negedge clk) begin
    if (bif.we === 1'b1) begin
      mon_we <= mon_we + 1;
      if (bif.pixeli !== (bif.pixelo ^ cur_plane)) mon_pix <= mon_pix + 1;
    end
    if (bif.mem_rd === 1'b1) begin
      mon_rd      <= mon_rd + 1;
      mon_rd_prev <= mon_rd_last;
      mon_rd_last <= bif.mem_addr;
    end
  end

  // reference: XOR plane into every set sprite pixel, collision when a set plane bit is hit
  task automatic model_draw(input logic [6:0] x, input logic [5:0] y, input logic [3:0] n,
                            input logic [11:0] a, input logic [1:0] pl,
                            output logic col, output int nw);
    logic [7:0] b;
    int hx, vy;
    col = 1'b0;
    nw = 0;
    for (int r = 0; r < int'(n); r++) begin
      b = prog[(int'(a) + r) % 4096];
      for (int c = 0; c < 8; c++) begin
        if (b[7-c] && pl != 2'b00) begin
          hx = int'(x) + c;
          vy = int'(y) + r;
`ifdef BLIT_CLIP_EN
          if (hx > 127 || vy > 63) continue;
`endif
          hx = hx % 128;
          vy = vy % 64;
          if ((mdisp[vy][hx] & pl) != 2'b00) col = 1'b1;
          mdisp[vy][hx] = mdisp[vy][hx] ^ pl;
          nw++;
        end
      end
    end
  endtask

  function automatic int disp_diffs();
    int d = 0;
    for (int v = 0; v < 64; v++)
      for (int h = 0; h < 128; h++)
        if (disp[v][h] !== mdisp[v][h]) d++;
    return d;
  endfunction

  task automatic clear_all();
    @(negedge clk); tb_clr = 1'b1;
    @(negedge clk); tb_clr = 1'b0;
    @(negedge clk);
    for (int v = 0; v < 64; v++)
      for (int h = 0; h < 128; h++)
        mdisp[v][h] = 2'b00;
  endtask

  // dc = cycle (1 = first after the start edge) in which done was seen, -1 on timeout
  task automatic draw(input logic [6:0] x, input logic [5:0] y, input logic [3:0] n,
                      input logic [11:0] a, input logic [1:0] pl,
                      output int dc, output int nw, output int nr, output int np);
    int we0, rd0, px0;
    @(negedge clk);
    cur_plane = pl;
    bif.x = x; bif.y = y; bif.n = n; bif.i = a; bif.plane = pl;
    bif.start = 1'b1;
    we0 = mon_we; rd0 = mon_rd; px0 = mon_pix;
    @(negedge clk);
    bif.start = 1'b0;
    dc = -1;
    for (int k = 1; k <= 300; k++) begin
      if (bif.done === 1'b1) begin
        dc = k;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    nw = mon_we - we0;
    nr = mon_rd - rd0;
    np = mon_pix - px0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tb_clr = 1'b1;
    bif.start = 1'b0; bif.x = '0; bif.y = '0; bif.n = '0; bif.i = '0; bif.plane = '0;
    repeat (4) @(negedge clk);
    tb_clr = 1'b0;
    @(negedge clk);
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bif.busy); end
    total++; if (bif.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bif.done); end
    total++; if (bif.collision !== 1'b0) begin bad++; $display("FAIL reset_collision got=%b want=0", bif.collision); end
    total++; if (bif.we !== 1'b0 || bif.mem_rd !== 1'b0) begin bad++; $display("FAIL reset_strobes we=%b rd=%b want=0", bif.we, bif.mem_rd); end
    total++; if (bif.mem_addr !== 12'h000) begin bad++; $display("FAIL reset_mem_addr got=%h want=000", bif.mem_addr); end
    total++; if (bif.hpos !== 7'd0 || bif.vpos !== 6'd0) begin bad++; $display("FAIL reset_pos h=%0d v=%0d want=0", bif.hpos, bif.vpos); end
    total++; if (bif.pixeli !== 2'b00) begin bad++; $display("FAIL reset_pixeli got=%b want=00", bif.pixeli); end
    reset = 1'b0;
    for (int v = 0; v < 64; v++)
      for (int h = 0; h < 128; h++)
        mdisp[v][h] = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int dc, nw, nr, np, mw;
    logic mc;
    prog[12'h200] = 8'hA5;
    draw(7'd10, 6'd5, 4'd1, 12'h200, 2'b01, dc, nw, nr, np);
    model_draw(7'd10, 6'd5, 4'd1, 12'h200, 2'b01, mc, mw);
    total++; if (dc != 19) begin bad++; $display("FAIL basic_done_cycle got=%0d want=19", dc); end
    total++; if (bif.collision !== 1'b0) begin bad++; $display("FAIL basic_collision got=%b want=0", bif.collision); end
    total++; if (nw != 4) begin bad++; $display("FAIL basic_writes got=%0d want=4", nw); end
    total++; if (nr != 1) begin bad++; $display("FAIL basic_reads got=%0d want=1", nr); end
    total++; if (np != 0) begin bad++; $display("FAIL basic_pixeli bad_cycles=%0d want=0", np); end
    total++;
    if (disp[5][10] !== 2'b01 || disp[5][12] !== 2'b01 || disp[5][15] !== 2'b01 || disp[5][17] !== 2'b01) begin
      bad++; $display("FAIL basic_pixels got=%b %b %b %b want=01", disp[5][10], disp[5][12], disp[5][15], disp[5][17]);
    end
    total++; if (disp_diffs() != 0) begin bad++; $display("FAIL basic_display diffs=%0d want=0", disp_diffs()); end
  endtask

  task automatic test_repeat();
    int dc, nw, nr, np, mw;
    logic mc;
    draw(7'd10, 6'd5, 4'd1, 12'h200, 2'b01, dc, nw, nr, np);
    model_draw(7'd10, 6'd5, 4'd1, 12'h200, 2'b01, mc, mw);
    total++; if (dc != 19) begin bad++; $display("FAIL repeat_done_cycle got=%0d want=19", dc); end
    total++; if (bif.collision !== 1'b1) begin bad++; $display("FAIL repeat_collision got=%b want=1", bif.collision); end
    total++;
    if (disp[5][10] !== 2'b00 || disp[5][12] !== 2'b00 || disp[5][15] !== 2'b00 || disp[5][17] !== 2'b00) begin
      bad++; $display("FAIL repeat_pixels got=%b %b %b %b want=00", disp[5][10], disp[5][12], disp[5][15], disp[5][17]);
    end
    total++; if (disp_diffs() != 0) begin bad++; $display("FAIL repeat_display diffs=%0d want=0", disp_diffs()); end
  endtask

  task automatic test_n_zero();
    int dc, nw, nr, np;
    draw(7'd3, 6'd3, 4'd0, 12'h123, 2'b11, dc, nw, nr, np);
    total++; if (dc != 1) begin bad++; $display("FAIL n0_done_cycle got=%0d want=1", dc); end
    total++; if (nr != 0 || nw != 0) begin bad++; $display("FAIL n0_traffic rd=%0d we=%0d want=0", nr, nw); end
    total++; if (bif.collision !== 1'b0) begin bad++; $display("FAIL n0_collision got=%b want=0", bif.collision); end
  endtask

  task automatic test_plane_zero();
    int dc, nw, nr, np, mw;
    logic mc;
    prog[12'h250] = 8'hFF; prog[12'h251] = 8'h81;
    draw(7'd10, 6'd5, 4'd2, 12'h250, 2'b00, dc, nw, nr, np);
    model_draw(7'd10, 6'd5, 4'd2, 12'h250, 2'b00, mc, mw);
    total++; if (dc != 37) begin bad++; $display("FAIL plane0_done_cycle got=%0d want=37", dc); end
    total++; if (nw != 0) begin bad++; $display("FAIL plane0_writes got=%0d want=0", nw); end
    total++; if (nr != 2) begin bad++; $display("FAIL plane0_reads got=%0d want=2", nr); end
    total++; if (bif.collision !== 1'b0) begin bad++; $display("FAIL plane0_collision got=%b want=0", bif.collision); end
  endtask

  task automatic test_clip();
    int dc, nw, nr, np, mw;
    logic mc;
    int exp_w;
    logic [1:0] exp_corner;
`ifdef BLIT_CLIP_EN
    exp_w = 8; exp_corner = 2'b00;
`else
    exp_w = 24; exp_corner = 2'b11;
`endif
    clear_all();
    prog[12'h400] = 8'hFF; prog[12'h401] = 8'hFF; prog[12'h402] = 8'hFF;
    draw(7'd124, 6'd62, 4'd3, 12'h400, 2'b11, dc, nw, nr, np);
    model_draw(7'd124, 6'd62, 4'd3, 12'h400, 2'b11, mc, mw);
    total++; if (dc != 55) begin bad++; $display("FAIL clip_done_cycle got=%0d want=55", dc); end
    total++; if (nw != exp_w) begin bad++; $display("FAIL clip_writes got=%0d want=%0d", nw, exp_w); end
    total++; if (disp[0][0] !== exp_corner) begin bad++; $display("FAIL clip_wrap_pixel got=%b want=%b", disp[0][0], exp_corner); end
    total++; if (disp[63][127] !== 2'b11) begin bad++; $display("FAIL clip_edge_pixel got=%b want=11", disp[63][127]); end
    total++; if (disp_diffs() != 0) begin bad++; $display("FAIL clip_display diffs=%0d want=0", disp_diffs()); end
  endtask

  task automatic test_mid_reset();
    int dc, nw, nr, np, mw, rd0;
    logic mc;
    clear_all();
    prog[12'h310] = 8'h80;
    draw(7'd20, 6'd20, 4'd1, 12'h310, 2'b01, dc, nw, nr, np);
    model_draw(7'd20, 6'd20, 4'd1, 12'h310, 2'b01, mc, mw);
    total++; if (disp[20][20] !== 2'b01) begin bad++; $display("FAIL midrst_setup got=%b want=01", disp[20][20]); end
    for (int k = 0; k < 4; k++) prog[12'h300 + k] = 8'hFF;
    @(negedge clk);
    cur_plane = 2'b01;
    bif.x = 7'd20; bif.y = 6'd20; bif.n = 4'd4; bif.i = 12'h300; bif.plane = 2'b01;
    bif.start = 1'b1;
    rd0 = mon_rd;
    @(negedge clk);
    bif.start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 3) begin bif.start = 1'b1; bif.i = 12'h500; bif.n = 4'd1; end
      if (k == 4) bif.start = 1'b0;
      if (k == 7) begin
        total++; if (bif.busy !== 1'b1 || bif.collision !== 1'b1) begin
          bad++; $display("FAIL midrst_pre busy=%b coll=%b want=1 1", bif.busy, bif.collision);
        end
        reset = 1'b1;
      end
      @(negedge clk);
    end
    total++; if (bif.busy !== 1'b0 || bif.we !== 1'b0 || bif.collision !== 1'b0) begin
      bad++; $display("FAIL midrst_after busy=%b we=%b coll=%b want=0", bif.busy, bif.we, bif.collision);
    end
    total++; if (mon_rd - rd0 != 1) begin bad++; $display("FAIL midrst_ignored_start reads=%0d want=1", mon_rd - rd0); end
    reset = 1'b0;
    clear_all();
  endtask

  task automatic test_addr_wrap();
    int dc, nw, nr, np, mw;
    logic mc;
    prog[12'hFFF] = 8'hC3; prog[12'h000] = 8'h3C;
    draw(7'd40, 6'd30, 4'd2, 12'hFFF, 2'b10, dc, nw, nr, np);
    model_draw(7'd40, 6'd30, 4'd2, 12'hFFF, 2'b10, mc, mw);
    total++; if (nr != 2 || mon_rd_prev !== 12'hFFF || mon_rd_last !== 12'h000) begin
      bad++; $display("FAIL wrap_fetch n=%0d a0=%h a1=%h want 2 fff 000", nr, mon_rd_prev, mon_rd_last);
    end
    total++; if (disp_diffs() != 0) begin bad++; $display("FAIL wrap_display diffs=%0d want=0", disp_diffs()); end
  endtask

  task automatic test_random();
    int dc, nw, nr, np, mw, exp_dc;
    logic mc;
    logic [6:0] x;
    logic [5:0] y;
    logic [3:0] n;
    logic [11:0] a;
    logic [1:0] pl;
    for (int t = 0; t < 100; t++) begin
      x = 7'($urandom_range(0, 127));
      y = 6'($urandom_range(0, 63));
      n = 4'($urandom_range(0, 15));
      a = 12'($urandom_range(0, 4095));
      pl = 2'($urandom_range(0, 3));
      draw(x, y, n, a, pl, dc, nw, nr, np);
      model_draw(x, y, n, a, pl, mc, mw);
      exp_dc = (n == 4'd0) ? 1 : 18 * int'(n) + 1;
      total++; if (dc != exp_dc) begin bad++; $display("FAIL rnd%0d_done_cycle got=%0d want=%0d", t, dc, exp_dc); end
      total++; if (bif.collision !== mc) begin bad++; $display("FAIL rnd%0d_collision got=%b want=%b", t, bif.collision, mc); end
      total++; if (nw != mw) begin bad++; $display("FAIL rnd%0d_writes got=%0d want=%0d", t, nw, mw); end
      total++; if (nr != int'(n)) begin bad++; $display("FAIL rnd%0d_reads got=%0d want=%0d", t, nr, n); end
      total++; if (np != 0) begin bad++; $display("FAIL rnd%0d_pixeli bad_cycles=%0d want=0", t, np); end
      total++; if (disp_diffs() != 0) begin bad++; $display("FAIL rnd%0d_display diffs=%0d want=0", t, disp_diffs()); end
    end
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) prog[k] = 8'($urandom);
    test_reset();
    test_basic();
    test_repeat();
    test_n_zero();
    test_plane_zero();
    test_clip();
    test_mid_reset();
    test_addr_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
